// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the fetch/execute sequencer: state encoding,
// opcodes and the bit positions of the internal control word.
package control_sequencer_pkg;

  typedef enum logic [2:0] {
    S_T0   = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_T3   = 3'd3,
    S_T4   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // Control word layout, shared by the ROM and the output unpacking.
  localparam int CW_PC_OUT   = 0;
  localparam int CW_PC_CE    = 1;
  localparam int CW_PC_JUMP  = 2;
  localparam int CW_MAR_LOAD = 3;
  localparam int CW_RAM_OUT  = 4;
  localparam int CW_RAM_LOAD = 5;
  localparam int CW_IR_LOAD  = 6;
  localparam int CW_IR_OUT   = 7;
  localparam int CW_A_LOAD   = 8;
  localparam int CW_A_OUT    = 9;
  localparam int CW_B_LOAD   = 10;
  localparam int CW_ALU_OUT  = 11;
  localparam int CW_ALU_SUB  = 12;
  localparam int CW_OUT_LOAD = 13;
  localparam int CW_HALTED   = 14;
  localparam int CW_W        = 15;

endpackage

// File: rtl/control_sequencer_rom.sv
// Combinational microcode: maps {state, opcode, flags} to a control word and
// a flag marking the final micro-step of the instruction.
module control_sequencer_rom
  import control_sequencer_pkg::*;
#(
  parameter int OPCODE_WIDTH = 4
) (
  input  state_t                  state,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic                    carry,
  input  logic                    zero,
  output logic [CW_W-1:0]         cw,
  output logic                    last
);

  // Decode the current micro-step; unlisted opcodes fall through as NOP.
  always_comb begin
    cw   = '0;
    last = 1'b0;
    case (state)
      S_T0: begin
        cw[CW_PC_OUT]   = 1'b1;
        cw[CW_MAR_LOAD] = 1'b1;
      end
      S_T1: begin
        cw[CW_RAM_OUT] = 1'b1;
        cw[CW_IR_LOAD] = 1'b1;
        cw[CW_PC_CE]   = 1'b1;
      end
      S_T2: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            cw[CW_IR_OUT]   = 1'b1;
            cw[CW_MAR_LOAD] = 1'b1;
          end
          OP_LDI: begin
            cw[CW_IR_OUT] = 1'b1;
            cw[CW_A_LOAD] = 1'b1;
            last          = 1'b1;
          end
          OP_JMP: begin
            cw[CW_IR_OUT]  = 1'b1;
            cw[CW_PC_JUMP] = 1'b1;
            last           = 1'b1;
          end
          OP_JC: begin
            cw[CW_IR_OUT]  = 1'b1;
            cw[CW_PC_JUMP] = carry;
            last           = 1'b1;
          end
          OP_JZ: begin
            cw[CW_IR_OUT]  = 1'b1;
            cw[CW_PC_JUMP] = zero;
            last           = 1'b1;
          end
          OP_OUT: begin
            cw[CW_A_OUT]    = 1'b1;
            cw[CW_OUT_LOAD] = 1'b1;
            last            = 1'b1;
          end
          default: last = 1'b1;
        endcase
      end
      S_T3: begin
        case (opcode)
          OP_LDA: begin
            cw[CW_RAM_OUT] = 1'b1;
            cw[CW_A_LOAD]  = 1'b1;
            last           = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            cw[CW_RAM_OUT] = 1'b1;
            cw[CW_B_LOAD]  = 1'b1;
            cw[CW_ALU_SUB] = (opcode == OP_SUB);
          end
          OP_STA: begin
            cw[CW_A_OUT]    = 1'b1;
            cw[CW_RAM_LOAD] = 1'b1;
            last            = 1'b1;
          end
          default: last = 1'b1;
        endcase
      end
      S_T4: begin
        if (opcode == OP_ADD || opcode == OP_SUB) begin
          cw[CW_ALU_OUT] = 1'b1;
          cw[CW_A_LOAD]  = 1'b1;
          cw[CW_ALU_SUB] = (opcode == OP_SUB);
        end
        last = 1'b1;
      end
      S_HALT: cw[CW_HALTED] = 1'b1;
      default: last = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Fetch/execute sequencer: T-state register, next-state logic, reset gating
// of every strobe, and unpacking of the control word onto the CPU strobes.
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int OPCODE_WIDTH = 4,
  parameter int TSTATE_WIDTH = 3
) (
  input  logic                    i_CLOCK,
  input  logic                    i_CLEAR_n,
  input  logic [OPCODE_WIDTH-1:0] i_OPCODE,
  input  logic                    i_CARRY,
  input  logic                    i_ZERO,
  output logic                    o_PC_OUTPUT,
  output logic                    o_PC_COUNT_ENABLE,
  output logic                    o_PC_JUMP,
  output logic                    o_MAR_LOAD,
  output logic                    o_RAM_OUTPUT,
  output logic                    o_RAM_LOAD,
  output logic                    o_IR_LOAD,
  output logic                    o_IR_OUTPUT,
  output logic                    o_A_LOAD,
  output logic                    o_A_OUTPUT,
  output logic                    o_B_LOAD,
  output logic                    o_ALU_OUTPUT,
  output logic                    o_ALU_SUBTRACT,
  output logic                    o_OUT_LOAD,
  output logic                    o_HALTED,
  output logic [TSTATE_WIDTH-1:0] o_TSTATE
);

  state_t            state_q, state_d;
  logic [CW_W-1:0]   cw_rom, cw_out;
  logic              last_step;

  control_sequencer_rom #(
    .OPCODE_WIDTH(OPCODE_WIDTH)
  ) u_rom (
    .state  (state_q),
    .opcode (i_OPCODE),
    .carry  (i_CARRY),
    .zero   (i_ZERO),
    .cw     (cw_rom),
    .last   (last_step)
  );

  // Advance one micro-step, return to T0 after the last one, park in HALT.
  always_comb begin
    state_d = state_q;
    if (state_q != S_HALT) begin
      if (last_step) begin
        if (state_q == S_T2 && i_OPCODE == OPCODE_WIDTH'(OP_HLT))
          state_d = S_HALT;
        else
          state_d = S_T0;
      end else begin
        state_d = state_t'(state_q + 3'd1);
      end
    end
  end

  // State register with synchronous active-low clear.
  always_ff @(posedge i_CLOCK) begin
    if (!i_CLEAR_n) state_q <= S_T0;
    else            state_q <= state_d;
  end

  // Hold every strobe low while clear is asserted, whatever the state.
  always_comb begin
    cw_out   = i_CLEAR_n ? cw_rom : '0;
    o_TSTATE = i_CLEAR_n ? TSTATE_WIDTH'(state_q) : '0;
  end

  assign o_PC_OUTPUT       = cw_out[CW_PC_OUT];
  assign o_PC_COUNT_ENABLE = cw_out[CW_PC_CE];
  assign o_PC_JUMP         = cw_out[CW_PC_JUMP];
  assign o_MAR_LOAD        = cw_out[CW_MAR_LOAD];
  assign o_RAM_OUTPUT      = cw_out[CW_RAM_OUT];
  assign o_RAM_LOAD        = cw_out[CW_RAM_LOAD];
  assign o_IR_LOAD         = cw_out[CW_IR_LOAD];
  assign o_IR_OUTPUT       = cw_out[CW_IR_OUT];
  assign o_A_LOAD          = cw_out[CW_A_LOAD];
  assign o_A_OUTPUT        = cw_out[CW_A_OUT];
  assign o_B_LOAD          = cw_out[CW_B_LOAD];
  assign o_ALU_OUTPUT      = cw_out[CW_ALU_OUT];
  assign o_ALU_SUBTRACT    = cw_out[CW_ALU_SUB];
  assign o_OUT_LOAD        = cw_out[CW_OUT_LOAD];
  assign o_HALTED          = cw_out[CW_HALTED];

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: table of directed instructions, halt and
// mid-instruction clear sequences, then a random instruction sweep.
module tb_control_sequencer;

  logic       clk = 1'b0;
  logic       clear_n;
  logic [3:0] opcode;
  logic       carry, zero;
  logic       pc_out, pc_ce, pc_jump, mar_load, ram_out, ram_load, ir_load;
  logic       ir_out, a_load, a_out, b_load, alu_out, alu_sub, out_load, halted;
  logic [2:0] tstate;

  control_sequencer dut (
    .i_CLOCK(clk), .i_CLEAR_n(clear_n), .i_OPCODE(opcode),
    .i_CARRY(carry), .i_ZERO(zero),
    .o_PC_OUTPUT(pc_out), .o_PC_COUNT_ENABLE(pc_ce), .o_PC_JUMP(pc_jump),
    .o_MAR_LOAD(mar_load), .o_RAM_OUTPUT(ram_out), .o_RAM_LOAD(ram_load),
    .o_IR_LOAD(ir_load), .o_IR_OUTPUT(ir_out), .o_A_LOAD(a_load),
    .o_A_OUTPUT(a_out), .o_B_LOAD(b_load), .o_ALU_OUTPUT(alu_out),
    .o_ALU_SUBTRACT(alu_sub), .o_OUT_LOAD(out_load), .o_HALTED(halted),
    .o_TSTATE(tstate)
  );

  always #5 clk = ~clk;

  // Bench-side strobe vector, one bit per named output.
  localparam logic [14:0] NONE     = 15'h0000;
  localparam logic [14:0] PC_OUT   = 15'h0001;
  localparam logic [14:0] PC_CE    = 15'h0002;
  localparam logic [14:0] PC_JUMP  = 15'h0004;
  localparam logic [14:0] MAR_LD   = 15'h0008;
  localparam logic [14:0] RAM_OUT  = 15'h0010;
  localparam logic [14:0] RAM_LD   = 15'h0020;
  localparam logic [14:0] IR_LD    = 15'h0040;
  localparam logic [14:0] IR_OUT   = 15'h0080;
  localparam logic [14:0] A_LD     = 15'h0100;
  localparam logic [14:0] A_OUT    = 15'h0200;
  localparam logic [14:0] B_LD     = 15'h0400;
  localparam logic [14:0] ALU_OUT  = 15'h0800;
  localparam logic [14:0] ALU_SUB  = 15'h1000;
  localparam logic [14:0] OUT_LD   = 15'h2000;
  localparam logic [14:0] HALTED   = 15'h4000;
  localparam logic [14:0] FETCH0   = PC_OUT | MAR_LD;
  localparam logic [14:0] FETCH1   = RAM_OUT | IR_LD | PC_CE;

  logic [14:0] obs;
  assign obs = {halted, out_load, alu_sub, alu_out, b_load, a_out, a_load,
                ir_out, ir_load, ram_load, ram_out, mar_load, pc_jump, pc_ce, pc_out};

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: instruction length and strobes per step, from the ISA.
  function automatic int ref_len(input logic [3:0] op);
    case (op)
      4'h1, 4'h4: return 4;
      4'h2, 4'h3: return 5;
      default:    return 3;
    endcase
  endfunction

  function automatic logic [14:0] ref_word(input logic [3:0] op, input logic c,
                                           input logic z, input int step);
    if (step == 0) return FETCH0;
    if (step == 1) return FETCH1;
    case (op)
      4'h1: return (step == 2) ? (IR_OUT | MAR_LD) : (RAM_OUT | A_LD);
      4'h2: return (step == 2) ? (IR_OUT | MAR_LD) :
                   (step == 3) ? (RAM_OUT | B_LD) : (ALU_OUT | A_LD);
      4'h3: return (step == 2) ? (IR_OUT | MAR_LD) :
                   (step == 3) ? (RAM_OUT | B_LD | ALU_SUB) : (ALU_OUT | A_LD | ALU_SUB);
      4'h4: return (step == 2) ? (IR_OUT | MAR_LD) : (A_OUT | RAM_LD);
      4'h5: return IR_OUT | A_LD;
      4'h6: return IR_OUT | PC_JUMP;
      4'h7: return c ? (IR_OUT | PC_JUMP) : IR_OUT;
      4'h8: return z ? (IR_OUT | PC_JUMP) : IR_OUT;
      4'hE: return A_OUT | OUT_LD;
      default: return NONE;
    endcase
  endfunction

  typedef struct packed {
    logic [3:0]  op;
    logic        c;
    logic        z;
    logic [2:0]  len;
    logic [14:0] w2;
    logic [14:0] w3;
    logic [14:0] w4;
  } vec_t;

  vec_t tbl [18];

  // Runs one instruction from T0, checking step number and strobes each cycle.
  task automatic run_instr(input string tag, input logic [3:0] op, input logic c,
                           input logic z, input int len, input logic [14:0] w2,
                           input logic [14:0] w3, input logic [14:0] w4);
    logic [14:0] exp;
    for (int s = 0; s < len; s++) begin
      opcode = op; carry = c; zero = z;
      @(negedge clk);
      exp = (s == 0) ? FETCH0 : (s == 1) ? FETCH1 : (s == 2) ? w2 : (s == 3) ? w3 : w4;
      chk({tag, "_tstate"}, 32'(tstate), 32'(s));
      chk({tag, "_strobes"}, 32'(obs), 32'(exp));
      @(posedge clk); #1;
    end
  endtask

  initial begin
    tbl[0]  = '{4'h0, 1'b0, 1'b0, 3'd3, NONE, NONE, NONE};
    tbl[1]  = '{4'h1, 1'b0, 1'b0, 3'd4, IR_OUT | MAR_LD, RAM_OUT | A_LD, NONE};
    tbl[2]  = '{4'h2, 1'b1, 1'b1, 3'd5, IR_OUT | MAR_LD, RAM_OUT | B_LD, ALU_OUT | A_LD};
    tbl[3]  = '{4'h3, 1'b0, 1'b0, 3'd5, IR_OUT | MAR_LD, RAM_OUT | B_LD | ALU_SUB,
                ALU_OUT | A_LD | ALU_SUB};
    tbl[4]  = '{4'h4, 1'b0, 1'b0, 3'd4, IR_OUT | MAR_LD, A_OUT | RAM_LD, NONE};
    tbl[5]  = '{4'h5, 1'b0, 1'b0, 3'd3, IR_OUT | A_LD, NONE, NONE};
    tbl[6]  = '{4'h6, 1'b0, 1'b0, 3'd3, IR_OUT | PC_JUMP, NONE, NONE};
    tbl[7]  = '{4'h7, 1'b0, 1'b0, 3'd3, IR_OUT, NONE, NONE};
    tbl[8]  = '{4'h7, 1'b1, 1'b0, 3'd3, IR_OUT | PC_JUMP, NONE, NONE};
    tbl[9]  = '{4'h7, 1'b0, 1'b1, 3'd3, IR_OUT, NONE, NONE};
    tbl[10] = '{4'h8, 1'b0, 1'b0, 3'd3, IR_OUT, NONE, NONE};
    tbl[11] = '{4'h8, 1'b0, 1'b1, 3'd3, IR_OUT | PC_JUMP, NONE, NONE};
    tbl[12] = '{4'h8, 1'b1, 1'b0, 3'd3, IR_OUT, NONE, NONE};
    tbl[13] = '{4'hE, 1'b0, 1'b0, 3'd3, A_OUT | OUT_LD, NONE, NONE};
    tbl[14] = '{4'hB, 1'b1, 1'b1, 3'd3, NONE, NONE, NONE};
    tbl[15] = '{4'h9, 1'b0, 1'b0, 3'd3, NONE, NONE, NONE};
    tbl[16] = '{4'hD, 1'b1, 1'b0, 3'd3, NONE, NONE, NONE};
    tbl[17] = '{4'h1, 1'b1, 1'b1, 3'd4, IR_OUT | MAR_LD, RAM_OUT | A_LD, NONE};

    // Reset held for two edges: everything forced low.
    clear_n = 1'b0; opcode = 4'h1; carry = 1'b0; zero = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("reset_strobes", 32'(obs), 32'(NONE));
      chk("reset_tstate", 32'(tstate), 32'd0);
      @(posedge clk); #1;
    end
    clear_n = 1'b1;

    // Directed table, back to back; each row starts where the last ended (T0).
    foreach (tbl[i])
      run_instr($sformatf("tbl%0d_op%0h", i, tbl[i].op), tbl[i].op, tbl[i].c, tbl[i].z,
                int'(tbl[i].len), tbl[i].w2, tbl[i].w3, tbl[i].w4);

    // JC: a carry present outside T2 must not cause a jump.
    opcode = 4'h7; carry = 1'b1; zero = 1'b1;
    @(negedge clk); chk("jc_flag_t0", 32'(obs), 32'(FETCH0));
    @(posedge clk); #1;
    @(negedge clk); chk("jc_flag_t1", 32'(obs), 32'(FETCH1));
    @(posedge clk); #1;
    carry = 1'b0;
    @(negedge clk); chk("jc_flag_t2", 32'(obs), 32'(IR_OUT));
    @(posedge clk); #1;

    // Halt: three fetch/exec steps, then parked with only HALTED set.
    run_instr("hlt", 4'hF, 1'b0, 1'b0, 3, NONE, NONE, NONE);
    for (int i = 0; i < 20; i++) begin
      opcode = 4'($urandom); carry = 1'($urandom); zero = 1'($urandom);
      @(negedge clk);
      chk("halt_tstate", 32'(tstate), 32'd5);
      chk("halt_strobes", 32'(obs), 32'(HALTED));
      @(posedge clk); #1;
    end
    clear_n = 1'b0;
    @(negedge clk);
    chk("halt_clear_strobes", 32'(obs), 32'(NONE));
    chk("halt_clear_tstate", 32'(tstate), 32'd0);
    @(posedge clk); #1;
    clear_n = 1'b1;
    run_instr("after_halt", 4'h0, 1'b0, 1'b0, 3, NONE, NONE, NONE);

    // Clear asserted during T3 of ADD: strobes drop at once, fetch restarts.
    run_instr("mid_add", 4'h2, 1'b0, 1'b0, 3, IR_OUT | MAR_LD, NONE, NONE);
    clear_n = 1'b0;
    @(negedge clk);
    chk("mid_clear_strobes", 32'(obs), 32'(NONE));
    chk("mid_clear_tstate", 32'(tstate), 32'd0);
    @(posedge clk); #1;
    clear_n = 1'b1;
    run_instr("after_mid", 4'h2, 1'b0, 1'b0, 5, IR_OUT | MAR_LD, RAM_OUT | B_LD, ALU_OUT | A_LD);

    // Random sweep: opcode only valid from T2, flags toggling every cycle.
    for (int n = 0; n < 1000; n++) begin
      logic [3:0] op;
      int len;
      logic [14:0] w, bus;
      op  = 4'($urandom_range(0, 14));
      len = ref_len(op);
      for (int s = 0; s < len; s++) begin
        opcode = (s < 2) ? 4'($urandom) : op;
        carry  = 1'($urandom);
        zero   = 1'($urandom);
        @(negedge clk);
        w   = ref_word(op, carry, zero, s);
        bus = obs & (PC_OUT | RAM_OUT | IR_OUT | A_OUT | ALU_OUT);
        chk("rnd_tstate", 32'(tstate), 32'(s));
        chk("rnd_strobes", 32'(obs), 32'(w));
        chk("rnd_bus_onehot", 32'($countones(bus) <= 1), 32'd1);
        chk("rnd_jump_vs_count", 32'(pc_jump & pc_ce), 32'd0);
        @(posedge clk); #1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Fetch/execute sequencer for the 8-bit bus CPU. It generates every bus and load strobe, including the program counter's count-enable, jump and output controls.
- It sits directly upstream of the program counter, instruction register, MAR, RAM, A/B registers, ALU and output register.
- It steps a T-state counter, decodes the opcode held in the instruction register, and ends each instruction early after its last micro-step.

Parameters:
- OPCODE_WIDTH, 4, width of opcode field from instruction register upper bits
- TSTATE_WIDTH, 3, width of T-state encoding (T0..T4 plus HALT)

Ports:
- i_CLOCK  input  1  single CPU clock; all state changes on rising edge
- i_CLEAR_n  input  1  synchronous active-low reset, sampled on rising edge of i_CLOCK
- i_OPCODE  input  OPCODE_WIDTH  opcode from instruction register; valid from T2 onward
- i_CARRY  input  1  carry flag from flags register
- i_ZERO  input  1  zero flag from flags register
- o_PC_OUTPUT  output  1  program counter drives bus
- o_PC_COUNT_ENABLE  output  1  program counter increments
- o_PC_JUMP  output  1  program counter loads from bus
- o_MAR_LOAD  output  1  MAR loads from bus
- o_RAM_OUTPUT  output  1  RAM drives bus
- o_RAM_LOAD  output  1  RAM writes bus
- o_IR_LOAD  output  1  instruction register loads from bus
- o_IR_OUTPUT  output  1  instruction register drives operand nibble onto bus
- o_A_LOAD, o_A_OUTPUT  output  1 each  A register load / drive
- o_B_LOAD  output  1  B register load
- o_ALU_OUTPUT  output  1  ALU drives bus
- o_ALU_SUBTRACT  output  1  ALU subtract select
- o_OUT_LOAD  output  1  output register load
- o_HALTED  output  1  sequencer halted
- o_TSTATE  output  TSTATE_WIDTH  current step, for debug display

Behaviour:
- Clocking and reset: one clock, i_CLOCK. Reset i_CLEAR_n is synchronous and active-low.
  - i_CLEAR_n low at a rising edge puts the state in T0.
  - While i_CLEAR_n is low, all strobes and o_HALTED are forced to 0 combinationally, and o_TSTATE reads 0.
  - Reset works from any state, including HALT and mid-instruction.
- States: T0, T1, T2, T3, T4, HALT (encoded 0-5 on o_TSTATE). Strobes are combinational decode of the registered state, i_OPCODE and the flags.
- Fetch, identical for all opcodes; i_OPCODE is ignored in these steps:
  - T0: PC_OUTPUT, MAR_LOAD.
  - T1: RAM_OUTPUT, IR_LOAD, PC_COUNT_ENABLE.
- Execute: the listed step is the last step. At the edge ending the last step the state returns to T0.
  - 0x0 NOP: T2 has no strobes; ends at T2, 3 cycles.
  - 0x1 LDA: T2 IR_OUTPUT+MAR_LOAD; T3 RAM_OUTPUT+A_LOAD; ends at T3, 4 cycles.
  - 0x2 ADD: T2 IR_OUTPUT+MAR_LOAD; T3 RAM_OUTPUT+B_LOAD; T4 ALU_OUTPUT+A_LOAD; ends at T4, 5 cycles.
  - 0x3 SUB: as ADD, with ALU_SUBTRACT high in T3 and T4.
  - 0x4 STA: T2 IR_OUTPUT+MAR_LOAD; T3 A_OUTPUT+RAM_LOAD; ends at T3.
  - 0x5 LDI: T2 IR_OUTPUT+A_LOAD; ends at T2.
  - 0x6 JMP: T2 IR_OUTPUT+PC_JUMP; ends at T2.
  - 0x7 JC: T2 IR_OUTPUT; PC_JUMP only if i_CARRY=1 during T2; ends at T2 either way.
  - 0x8 JZ: as JC, using i_ZERO.
  - 0xE OUT: T2 A_OUTPUT+OUT_LOAD; ends at T2.
  - 0xF HLT: T2 has no strobes; next state HALT.
  - Undefined opcodes (0x9-0xD) execute as NOP.
- HALT: all strobes 0, o_HALTED=1. HALT is held until i_CLEAR_n is low at a rising edge.
- Invariant: at most one of PC_OUTPUT, RAM_OUTPUT, IR_OUTPUT, A_OUTPUT, ALU_OUTPUT is high in any cycle. PC_JUMP and PC_COUNT_ENABLE are never both high.
- Flags are sampled combinationally during T2 only; changes in other steps have no effect.

Decomposition:
- Shared include xdn_defs.vh holds:
  - opcode localparams (OP_NOP..OP_HLT)
  - T-state encodings
  - control-word bit indices, so the ROM and the top level agree
- Sub-module control_rom: purely combinational map from {state, opcode, carry, zero} to a control word plus a last-step bit.
- control_sequencer holds the state register, next-state logic, reset gating and output unpacking.

Test Plan:
- Reset then LDA: i_CLEAR_n low 2 cycles, then high with i_OPCODE=0x1 → strobe sets T0 {PC_OUTPUT,MAR_LOAD}, T1 {RAM_OUTPUT,IR_LOAD,PC_COUNT_ENABLE}, T2 {IR_OUTPUT,MAR_LOAD}, T3 {RAM_OUTPUT,A_LOAD}, then T0 again. Cycle 5 shows o_TSTATE=0.
- ADD vs SUB: opcode 0x2 → 5-cycle instruction, ALU_SUBTRACT=0 throughout. Opcode 0x3 → ALU_SUBTRACT=1 in T3 and T4 only.
- Conditional jump: opcode 0x7 with i_CARRY=0 → no PC_JUMP, 3 cycles. With i_CARRY=1 → PC_JUMP=1 in T2 only. Repeat for 0x8/i_ZERO.
- Halt: opcode 0xF → T2 has no strobes, then o_HALTED=1 and o_TSTATE=5 for 20 cycles with all strobes 0. i_CLEAR_n low one edge → T0, o_HALTED=0.
- Reset mid-instruction: opcode 0x2, assert i_CLEAR_n low during T3 → all strobes 0 in that cycle. After release, fetch restarts at T0; no A_LOAD is issued.
- Undefined opcode 0xB → behaves as NOP (3 cycles, T2 has no strobes). Bus-driver one-hot assertion holds across a random opcode sweep of 1000 instructions.
